// File: rtl/sram_bank_array.sv
// Banked single-port SRAM over SRAM1RW512x8 macros with valid/ready requests and one BISR spare bank.
// Reads complete a fixed 2 cycles after accept; REQ_READY drops only while a repair config loads.
module sram_bank_array #(
  parameter  int NUM_BANKS = 4,
  parameter  int DATA_W    = 8,
  parameter  int SPARE_EN  = 1,
  localparam int BANK_W    = $clog2(NUM_BANKS),
  localparam int ADDR_W    = BANK_W + 9,
  localparam int L         = DATA_W / 8
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [L-1:0]      REQ_BE,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RD_VALID,
  output logic [DATA_W-1:0] RD_DATA,
  input  logic              CFG_WE,
  input  logic              CFG_REPAIR_EN,
  input  logic [BANK_W-1:0] CFG_REPAIR_BANK,
  output logic              REPAIR_ACTIVE,
  output logic [BANK_W-1:0] REPAIR_BANK
);
  localparam int P = NUM_BANKS + SPARE_EN;

  logic              repair_active_q, repair_active_d;
  logic [BANK_W-1:0] repair_bank_q, repair_bank_d;
  logic [P-1:0]      rd_sel_q, rd_sel_d;
  logic              rd_flag_q, rd_flag_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              accept;
  logic [BANK_W-1:0] req_bank;
  logic [8:0]        req_row;
  logic              remap;
  logic [P-1:0]      phys_sel;
  logic [P*L-1:0]    mac_csb, mac_web, mac_oeb;
  logic [7:0]        mac_o [P*L];
  logic [DATA_W-1:0] merged;

  assign REQ_READY = RSTN & ~CFG_WE;
  assign accept    = REQ_VALID & REQ_READY;
  assign req_bank  = REQ_ADDR[ADDR_W-1:9];
  assign req_row   = REQ_ADDR[8:0];
  assign remap     = (SPARE_EN != 0) & repair_active_q & (req_bank == repair_bank_q);

  always_comb begin
    phys_sel = '0;
    if (remap) phys_sel[P-1] = 1'b1;
    else       phys_sel[req_bank] = 1'b1;
  end

  // Byte-disabled write lanes stay deselected so the macro sees no access at all.
  always_comb begin
    mac_csb = '1;
    mac_web = '1;
    mac_oeb = '1;
    for (int p = 0; p < P; p++) begin
      for (int l = 0; l < L; l++) begin
        if (accept && phys_sel[p] && (!REQ_WE || REQ_BE[l])) begin
          mac_csb[p*L+l] = 1'b0;
          mac_web[p*L+l] = ~REQ_WE;
        end
        if (RSTN && rd_flag_q && rd_sel_q[p]) mac_oeb[p*L+l] = 1'b0;
      end
    end
  end

  always_comb begin
    merged = '0;
    for (int p = 0; p < P; p++) begin
      for (int l = 0; l < L; l++) begin
        merged[l*8 +: 8] = merged[l*8 +: 8] | (mac_o[p*L+l] & {8{~mac_oeb[p*L+l]}});
      end
    end
  end

  always_comb begin
    repair_active_d = repair_active_q;
    repair_bank_d   = repair_bank_q;
    if (CFG_WE) begin
      repair_active_d = CFG_REPAIR_EN;
      repair_bank_d   = CFG_REPAIR_BANK;
    end
    rd_flag_d  = accept & ~REQ_WE;
    rd_sel_d   = (accept & ~REQ_WE) ? phys_sel : '0;
    rd_valid_d = rd_flag_q;
    rd_data_d  = rd_flag_q ? merged : rd_data_q;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      repair_active_q <= 1'b0;
      repair_bank_q   <= '0;
      rd_sel_q        <= '0;
      rd_flag_q       <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_data_q       <= '0;
    end else begin
      repair_active_q <= repair_active_d;
      repair_bank_q   <= repair_bank_d;
      rd_sel_q        <= rd_sel_d;
      rd_flag_q       <= rd_flag_d;
      rd_valid_q      <= rd_valid_d;
      rd_data_q       <= rd_data_d;
    end
  end

  assign RD_VALID      = rd_valid_q;
  assign RD_DATA       = rd_data_q;
  assign REPAIR_ACTIVE = repair_active_q & (SPARE_EN != 0);
  assign REPAIR_BANK   = repair_bank_q;

  for (genvar gp = 0; gp < P; gp++) begin : g_bank
    for (genvar gl = 0; gl < L; gl++) begin : g_lane
      SRAM1RW512x8 u_mac (
        .A   (req_row),
        .CE  (CLK),
        .I   (REQ_WDATA[gl*8 +: 8]),
        .O   (mac_o[gp*L+gl]),
        .CSB (mac_csb[gp*L+gl]),
        .WEB (mac_web[gp*L+gl]),
        .OEB (mac_oeb[gp*L+gl])
      );
    end
  end
endmodule

// Behavioural model of the 512x8 single-port macro; the undriven output is modelled
// as all-ones so the wrapper's OEB gating is what keeps idle banks out of the merge.
module SRAM1RW512x8 (
  input  logic [8:0] A,
  input  logic       CE,
  input  logic [7:0] I,
  output logic [7:0] O,
  input  logic       CSB,
  input  logic       WEB,
  input  logic       OEB
);
  logic [7:0] mem_q [512];
  logic [7:0] dout_q;

  always_ff @(posedge CE) begin
    if (!CSB) begin
      if (!WEB) mem_q[A] <= I;
      else      dout_q   <= mem_q[A];
    end
  end

  assign O = OEB ? 8'hFF : dout_q;
endmodule

// File: doc/sram_bank_array.md
Name: sram_bank_array

Overview:
Parametrised banked single-port SRAM array built from SRAM1RW512x8 macros: NUM_BANKS logical banks, each DATA_W/8 byte lanes wide and 512 words deep. Adds a valid/ready request port, per-byte write enables, a registered 2-cycle read pipeline with gated OR-merge of bank outputs, and a single spare bank for built-in self repair (BISR) remap of one faulty logical bank. Sits between the memory controller datapath and the raw macros, replacing the fixed 4x512x8 bank wrapper.

Parameters:
NUM_BANKS, 4, logical bank count; power of two, 2..16
DATA_W, 8, word width; multiple of 8, 8..64; lanes L = DATA_W/8
SPARE_EN, 1, 1 = instantiate spare bank and repair remap; 0 = no spare, repair config ignored
BANK_W, log2(NUM_BANKS), derived, not overridden
ADDR_W, BANK_W+9, derived, not overridden

Ports:
CLK  input  1  clock; also drives every macro CE
RSTN  input  1  asynchronous active-low reset
REQ_VALID  input  1  request present
REQ_READY  output  1  request accepted when VALID&READY at rising CLK
REQ_WE  input  1  1 = write, 0 = read
REQ_ADDR  input  ADDR_W  {bank[BANK_W-1:0], row[8:0]}
REQ_BE  input  L  per-byte write enable; ignored on reads
REQ_WDATA  input  DATA_W  write data
RD_VALID  output  1  one-cycle pulse, read data valid
RD_DATA  output  DATA_W  read data, registered
CFG_WE  input  1  load repair config this cycle
CFG_REPAIR_EN  input  1  repair enable value to load
CFG_REPAIR_BANK  input  BANK_W  faulty logical bank to remap
REPAIR_ACTIVE  output  1  repair enable register
REPAIR_BANK  output  BANK_W  repair bank register

Behaviour:
- Physical banks P = NUM_BANKS + SPARE_EN; each is L macros. Macro pins: A = row, CE = CLK, I = lane slice of REQ_WDATA, CSB/WEB/OEB per macro.
- Reset (RSTN low, async): RD_VALID=0, RD_DATA=0, REPAIR_ACTIVE=0, REPAIR_BANK=0, read pipeline cleared, REQ_READY=0. All CSB=1, WEB=1, OEB=1 while reset is asserted.
- REQ_READY = RSTN & ~CFG_WE, combinational. Requests are never accepted in a CFG_WE cycle.
- Mapping: phys = (SPARE_EN & REPAIR_ACTIVE & bank==REPAIR_BANK) ? NUM_BANKS : bank. Uses register values current in the accept cycle.
- Accept cycle (cycle 0): CSB low for the addressed phys bank only. All other banks keep CSB=1.
- Write: WEB low on lanes with REQ_BE=1. Lanes with BE=0 keep CSB=1, so no access. A write with BE=0 is accepted with no macro access. Writes produce no response.
- Read: all L lanes of the phys bank selected with WEB=1. A one-hot phys select plus a read flag are registered at the accept edge.
- Cycle 1: OEB low only for the registered one-hot bank. Each macro output is ANDed with ~OEB, then ORed across banks per lane. Unselected banks contribute 0. Merged data is registered at the end of cycle 1.
- Cycle 2: RD_VALID=1 for exactly one cycle, RD_DATA = merged data. RD_DATA holds its value until the next read completes. Latency is fixed at 2 cycles; throughput is 1 request/cycle. Responses are in order.
- Back-to-back reads to different or the same banks: each completes 2 cycles after its own accept; no bubbles.
- Read following a write to the same address in the next cycle returns the new data.
- CFG_WE: at the rising edge, REPAIR_ACTIVE<=CFG_REPAIR_EN and REPAIR_BANK<=CFG_REPAIR_BANK. In-flight reads keep the phys select captured at accept. With SPARE_EN=0, the registers still load, but remap never occurs and REPAIR_ACTIVE reads 0.
- Remap covers reads and writes alike. The spare bank holds no copy of prior data, so software rewrites the bank after enabling repair.
- Reset mid-read: the pending RD_VALID is dropped and no response is issued after RSTN rises.
- REQ_VALID with REQ_READY=0: no macro access, nothing registered.

Test Plan:
- NUM_BANKS=4, DATA_W=16: write 0xA55A to addr {2,0x1FF} with BE=2'b11, then read it -> RD_VALID exactly 2 cycles after accept, RD_DATA=0xA55A; no other bank has CSB low in either cycle.
- Byte enable: write 0x1234 to {1,0x010}, then write 0xFFFF with BE=2'b10, then read -> 0xFF34.
- Streaming: reads on 4 consecutive cycles to banks 0,1,2,3 pre-loaded with 0x0000,0x1111,0x2222,0x3333 -> RD_VALID high 4 consecutive cycles, data in that order; unselected OEB=1 each cycle.
- Repair: CFG_WE with EN=1, BANK=3, during which REQ_VALID=1 -> REQ_READY=0, nothing accepted. Then write 0xBEEF to {3,0x005} and read -> spare macros accessed, bank 3 CSB stays 1, RD_DATA=0xBEEF. Then disable repair -> read of {3,0x005} returns bank 3's original content.
- Config during flight: read bank 3 in cycle 0, CFG_WE enabling repair of bank 3 in cycle 1 -> response comes from physical bank 3 data.
- Async reset asserted in cycle 1 of a read -> RD_VALID stays 0 through and after reset; REPAIR_ACTIVE=0 and REQ_READY=0 while RSTN is low.
